baud_cfg_ctrl: RTL and testbench

Configuration scheduler for the UART baud rate generator; owns the generator's 2-bit sel_baud input.
Arbitrates baud-change requests from two requesters: A = host/register interface, B = autobaud detector.
Applies a change only after the TX/RX link has drained, then waits a settle period before reporting completion.
Sits between the requesters, the baud generator and the uart TX/RX engines.

---
 rtl/baud_cfg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_baud_cfg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl
// Configuration scheduler for the UART baud rate generator. It owns the
// generator's 2-bit sel_baud input and arbitrates baud-change requests from
// two requesters (A = host/register interface, B = autobaud detector).
// A change is applied only once the TX/RX link has drained. After the change
// the block waits a settle period, counted in bclkx8 rising edges, and then
// reports completion.
//
// Ports:
//   sys_clk      system clock; all logic on its rising edge
//   rst          synchronous active-high reset
//   req_a_*      requester A valid/sel/ready handshake
//   req_b_*      requester B valid/sel/ready handshake
//   tx_busy      transmitter mid-frame
//   rx_busy      receiver mid-frame
//   bclkx8       8x baud clock, sampled as data in the sys_clk domain
//   cfg_lock     (BAUD_CFG_LOCK_EN only) blocks grants to requester B
//   sel_baud     baud select driven to the generator
//   link_hold    TX/RX must not start new frames while high
//   cfg_done     one-cycle pulse when a request completes
//   timeout_err  one-cycle pulse when a request is aborted while draining
//
// Optional feature macro: BAUD_CFG_LOCK_EN adds the cfg_lock input.
module baud_cfg_ctrl #(
  parameter logic [1:0]  RESET_SEL     = 2'b00,
  parameter int unsigned SETTLE_TICKS  = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1000000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_a_valid,
  input  logic [1:0] req_a_sel,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [1:0] req_b_sel,
  output logic       req_b_ready,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       bclkx8,
`ifdef BAUD_CFG_LOCK_EN
  input  logic       cfg_lock,
`endif
  output logic [1:0] sel_baud,
  output logic       link_hold,
  output logic       cfg_done,
  output logic       timeout_err
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int TW = $clog2(SETTLE_TICKS + 1);
  localparam logic [DW-1:0] DRAIN_LIMIT  = DW'(DRAIN_TIMEOUT);
  localparam logic [TW-1:0] SETTLE_LIMIT = TW'(SETTLE_TICKS);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, SETTLE} state_t;

  state_t        state, state_next;
  logic          rr_ptr, rr_next;
  logic [1:0]    pend_sel, pend_next;
  logic [1:0]    sel_next;
  logic [DW-1:0] drain_cnt, drain_next, drain_inc;
  logic [TW-1:0] tick_cnt, tick_next, tick_inc;
  logic          hold_next, done_next, terr_next;
  logic          bclkx8_q, tick;
  logic          b_eligible, grant_a, grant_b, xfer;
  logic [1:0]    grant_sel;

  // bclkx8 is asynchronous-looking data here; a rising edge is one tick.
  assign tick = bclkx8 & ~bclkx8_q;

`ifdef BAUD_CFG_LOCK_EN
  assign b_eligible = req_b_valid & ~cfg_lock;
`else
  assign b_eligible = req_b_valid;
`endif

  // rr_ptr = 0 favours A, 1 favours B; it only matters when both compete.
  assign grant_a     = req_a_valid & (~b_eligible | ~rr_ptr);
  assign grant_b     = b_eligible & (~req_a_valid | rr_ptr);
  assign req_a_ready = (state == IDLE) & grant_a;
  assign req_b_ready = (state == IDLE) & grant_b;
  assign xfer        = req_a_ready | req_b_ready;
  assign grant_sel   = grant_b ? req_b_sel : req_a_sel;

  // Counters never exceed their terminal value, so the increment cannot wrap.
  assign drain_inc = drain_cnt + DW'(1);
  assign tick_inc  = tick_cnt + TW'(1);

  // State register and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      pend_sel    <= RESET_SEL;
      sel_baud    <= RESET_SEL;
      drain_cnt   <= '0;
      tick_cnt    <= '0;
      link_hold   <= 1'b0;
      cfg_done    <= 1'b0;
      timeout_err <= 1'b0;
      bclkx8_q    <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_next;
      pend_sel    <= pend_next;
      sel_baud    <= sel_next;
      drain_cnt   <= drain_next;
      tick_cnt    <= tick_next;
      link_hold   <= hold_next;
      cfg_done    <= done_next;
      timeout_err <= terr_next;
      bclkx8_q    <= bclkx8;
    end
  end

  // Next-state and next-output logic. A request equal to the current select
  // completes immediately without holding the link.
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    pend_next  = pend_sel;
    sel_next   = sel_baud;
    drain_next = drain_cnt;
    tick_next  = tick_cnt;
    hold_next  = link_hold;
    done_next  = 1'b0;
    terr_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          rr_next   = ~rr_ptr;
          pend_next = grant_sel;
          if (grant_sel == sel_baud) begin
            done_next = 1'b1;
          end else begin
            state_next = DRAIN;
            hold_next  = 1'b1;
            drain_next = '0;
          end
        end
      end
      DRAIN: begin
        // An idle link takes priority over a timeout in the same cycle.
        if (!tx_busy && !rx_busy) begin
          state_next = APPLY;
        end else begin
          drain_next = drain_inc;
          if (drain_inc == DRAIN_LIMIT) begin
            state_next = IDLE;
            hold_next  = 1'b0;
            terr_next  = 1'b1;
          end
        end
      end
      APPLY: begin
        // A tick in this cycle is deliberately ignored.
        sel_next   = pend_sel;
        tick_next  = '0;
        state_next = SETTLE;
      end
      SETTLE: begin
        if (tick) begin
          tick_next = tick_inc;
          if (tick_inc == SETTLE_LIMIT) begin
            state_next = IDLE;
            hold_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl
// Self-checking bench for baud_cfg_ctrl. A table of single-request vectors
// covers change, no-change, drain delay, drain timeout and the idle/timeout
// boundary. Hand-written sequences cover reset, arbitration, round-robin,
// reset during SETTLE and (when BAUD_CFG_LOCK_EN is defined) cfg_lock.
// Inputs and outputs are both handled at the falling edge of sys_clk.
module tb_baud_cfg_ctrl;

  localparam int SETTLE = 16;
  localparam int DTO    = 50;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       req_a_valid, req_b_valid;
  logic [1:0] req_a_sel, req_b_sel;
  logic       req_a_ready, req_b_ready;
  logic       tx_busy, rx_busy;
  logic       bclkx8;
  logic [1:0] sel_baud;
  logic       link_hold, cfg_done, timeout_err;
`ifdef BAUD_CFG_LOCK_EN
  logic       cfg_lock;
`endif

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic       use_b;
    logic [1:0] sel;
    int         busy_cycles;
    logic       busy_rx;
    logic       exp_done;
    logic [1:0] exp_sel;
    logic       exp_hold;
  } vec_t;

  vec_t vecs[8];

  baud_cfg_ctrl #(
    .RESET_SEL    (2'b00),
    .SETTLE_TICKS (SETTLE),
    .DRAIN_TIMEOUT(DTO)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .req_a_valid(req_a_valid),
    .req_a_sel  (req_a_sel),
    .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid),
    .req_b_sel  (req_b_sel),
    .req_b_ready(req_b_ready),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy),
    .bclkx8     (bclkx8),
`ifdef BAUD_CFG_LOCK_EN
    .cfg_lock   (cfg_lock),
`endif
    .sel_baud   (sel_baud),
    .link_hold  (link_hold),
    .cfg_done   (cfg_done),
    .timeout_err(timeout_err)
  );

  // 100 MHz-style system clock.
  initial forever #5 sys_clk = ~sys_clk;

  // bclkx8 toggles every 3 sys_clk cycles, changing 2 units after a rising
  // edge so it is never racing the DUT sample or the falling-edge checks.
  initial begin
    bclkx8 = 1'b0;
    forever begin
      repeat (3) @(posedge sys_clk);
      #2 bclkx8 = ~bclkx8;
    end
  end

  // Hard stop in case a wait is ever left unbounded by mistake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and reports a failure with both values.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Waits at falling edges for cfg_done; cycles = -1 if the bound expires.
  // Also reports whether req_b_ready was ever seen while waiting.
  task automatic waitDone(input int limit, output int cycles, output logic b_ready_seen);
    cycles       = -1;
    b_ready_seen = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (cfg_done) begin
        cycles = k;
        break;
      end
      if (req_b_ready) b_ready_seen = 1'b1;
      @(negedge sys_clk);
    end
  endtask

  // Runs one table vector from an IDLE falling edge. Index 0 is the edge
  // where ready is seen; index k is the k-th falling edge after that.
  // For a real change, cfg_done must appear one edge after the edge where
  // the 16th bclkx8 rise is seen in SETTLE (the first edge showing the new
  // sel_baud). A timeout must appear at index DTO+1, i.e. DTO cycles after
  // entering DRAIN.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   end_idx, rise_idx, rises, exp_lat;
    logic got_done, got_to, settle_seen, hold_seen, prev;
    end_idx = 0; rise_idx = -1; rises = 0;
    got_done = 1'b0; got_to = 1'b0; settle_seen = 1'b0; hold_seen = 1'b0;
    tx_busy = (v.busy_cycles > 0) && !v.busy_rx;
    rx_busy = (v.busy_cycles > 0) && v.busy_rx;
    if (v.use_b) begin
      req_b_valid = 1'b1; req_b_sel = v.sel;
    end else begin
      req_a_valid = 1'b1; req_a_sel = v.sel;
    end
    #1;
    checkOutput({tag, "_ready_granted"}, int'(v.use_b ? req_b_ready : req_a_ready), 1);
    checkOutput({tag, "_ready_other"}, int'(v.use_b ? req_a_ready : req_b_ready), 0);
    prev = bclkx8;
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    for (int idx = 1; idx <= 400; idx++) begin
      if (cfg_done || timeout_err) begin
        got_done = cfg_done;
        got_to   = timeout_err;
        end_idx  = idx;
        break;
      end
      if (link_hold) hold_seen = 1'b1;
      if (!settle_seen && v.exp_hold && sel_baud == v.sel) settle_seen = 1'b1;
      if (settle_seen && bclkx8 && !prev) begin
        rises++;
        if (rises == SETTLE) rise_idx = idx;
      end
      prev = bclkx8;
      if (idx == v.busy_cycles + 1) begin
        tx_busy = 1'b0;
        rx_busy = 1'b0;
      end
      @(negedge sys_clk);
    end
    if (!v.exp_done) exp_lat = DTO + 1;
    else if (v.exp_hold) exp_lat = rise_idx + 1;
    else exp_lat = 1;
    checkOutput({tag, "_outcome_done_to"}, int'({got_done, got_to}), int'({v.exp_done, ~v.exp_done}));
    checkOutput({tag, "_latency"}, end_idx, exp_lat);
    checkOutput({tag, "_sel_baud"}, int'(sel_baud), int'(v.exp_sel));
    checkOutput({tag, "_hold_seen"}, int'(hold_seen), int'(v.exp_hold));
    checkOutput({tag, "_hold_end"}, int'(link_hold), 0);
    @(negedge sys_clk);
    checkOutput({tag, "_pulse_width"}, int'({cfg_done, timeout_err}), 0);
    tx_busy = 1'b0;
    rx_busy = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic b_seen, any_pulse, any_hold, sel_bad;

    // Fields: use_b, sel, busy_cycles, busy_rx, exp_done, exp_sel, exp_hold.
    vecs[0] = '{1'b0, 2'b10, 0,   1'b0, 1'b1, 2'b10, 1'b1}; // plain change
    vecs[1] = '{1'b1, 2'b10, 0,   1'b0, 1'b1, 2'b10, 1'b0}; // same sel
    vecs[2] = '{1'b1, 2'b01, 10,  1'b0, 1'b1, 2'b01, 1'b1}; // tx drains late
    vecs[3] = '{1'b0, 2'b11, 100, 1'b1, 1'b0, 2'b01, 1'b1}; // rx stuck
    vecs[4] = '{1'b0, 2'b00, 49,  1'b1, 1'b1, 2'b00, 1'b1}; // idle wins
    vecs[5] = '{1'b1, 2'b11, 50,  1'b0, 1'b0, 2'b00, 1'b1}; // exact timeout
    vecs[6] = '{1'b0, 2'b11, 0,   1'b0, 1'b1, 2'b11, 1'b1}; // plain change
    vecs[7] = '{1'b0, 2'b11, 5,   1'b0, 1'b1, 2'b11, 1'b0}; // same, busy

    rst = 1'b1;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    req_a_sel = 2'b00;  req_b_sel = 2'b00;
    tx_busy = 1'b0;     rx_busy = 1'b0;
`ifdef BAUD_CFG_LOCK_EN
    cfg_lock = 1'b0;
`endif
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_sel_baud", int'(sel_baud), 0);
    checkOutput("reset_link_hold", int'(link_hold), 0);
    checkOutput("reset_pulses", int'({cfg_done, timeout_err}), 0);
    rst = 1'b0;

    // Quiet period: nothing may move without a request.
    any_pulse = 1'b0; any_hold = 1'b0; sel_bad = 1'b0;
    repeat (100) begin
      @(negedge sys_clk);
      if (cfg_done || timeout_err) any_pulse = 1'b1;
      if (link_hold) any_hold = 1'b1;
      if (sel_baud != 2'b00) sel_bad = 1'b1;
    end
    checkOutput("quiet_pulses", int'(any_pulse), 0);
    checkOutput("quiet_hold", int'(any_hold), 0);
    checkOutput("quiet_sel_changed", int'(sel_bad), 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Arbitration from reset: pointer favours A, B waits for IDLE.
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    req_a_valid = 1'b1; req_a_sel = 2'b01;
    req_b_valid = 1'b1; req_b_sel = 2'b11;
    #1;
    checkOutput("arb_a_ready", int'(req_a_ready), 1);
    checkOutput("arb_b_not_ready", int'(req_b_ready), 0);
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    waitDone(400, cyc, b_seen);
    checkOutput("arb_a_done_seen", int'(cyc > 0), 1);
    checkOutput("arb_b_blocked_during_change", int'(b_seen), 0);
    checkOutput("arb_sel_after_a", int'(sel_baud), 1);
    checkOutput("arb_b_ready_first_idle", int'(req_b_ready), 1);
    @(negedge sys_clk);
    req_b_valid = 1'b0;
    waitDone(400, cyc, b_seen);
    checkOutput("arb_b_done_seen", int'(cyc > 0), 1);
    checkOutput("arb_final_sel", int'(sel_baud), 3);

    // Round-robin: a no-change A transfer moves the pointer to B.
    @(negedge sys_clk);
    req_a_valid = 1'b1; req_a_sel = 2'b11;
    #1;
    checkOutput("rr_a_alone_ready", int'(req_a_ready), 1);
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    checkOutput("rr_nochange_done", int'(cfg_done), 1);
    checkOutput("rr_nochange_hold", int'(link_hold), 0);
    @(negedge sys_clk);
    req_a_valid = 1'b1; req_a_sel = 2'b10;
    req_b_valid = 1'b1; req_b_sel = 2'b01;
    #1;
    checkOutput("rr_b_wins", int'(req_b_ready), 1);
    checkOutput("rr_a_loses", int'(req_a_ready), 0);
    @(negedge sys_clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    waitDone(400, cyc, b_seen);
    checkOutput("rr_b_done_seen", int'(cyc > 0), 1);
    checkOutput("rr_b_sel", int'(sel_baud), 1);

    // Reset while settling on 11 abandons the change.
    @(negedge sys_clk);
    req_a_valid = 1'b1; req_a_sel = 2'b11;
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    cyc = -1;
    for (int k = 0; k < 50; k++) begin
      if (sel_baud == 2'b11) begin
        cyc = k;
        break;
      end
      @(negedge sys_clk);
    end
    checkOutput("rst_settle_reached", int'(cyc >= 0), 1);
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_settle_hold_high", int'(link_hold), 1);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    checkOutput("rst_settle_sel", int'(sel_baud), 0);
    checkOutput("rst_settle_hold", int'(link_hold), 0);
    checkOutput("rst_settle_done", int'(cfg_done), 0);
    req_a_valid = 1'b1; req_a_sel = 2'b00;
    #1;
    checkOutput("rst_idle_ready", int'(req_a_ready), 1);
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    checkOutput("rst_idle_done", int'(cfg_done), 1);
    checkOutput("rst_idle_hold", int'(link_hold), 0);
    @(negedge sys_clk);
    checkOutput("rst_idle_done_drop", int'(cfg_done), 0);

`ifdef BAUD_CFG_LOCK_EN
    // Pointer now favours B, but the lock must still hand the slot to A.
    cfg_lock = 1'b1;
    req_a_valid = 1'b1; req_a_sel = 2'b10;
    req_b_valid = 1'b1; req_b_sel = 2'b11;
    #1;
    checkOutput("lock_a_ready", int'(req_a_ready), 1);
    checkOutput("lock_b_blocked", int'(req_b_ready), 0);
    @(negedge sys_clk);
    req_a_valid = 1'b0;
    waitDone(400, cyc, b_seen);
    checkOutput("lock_a_done_seen", int'(cyc > 0), 1);
    checkOutput("lock_b_never_ready", int'(b_seen), 0);
    checkOutput("lock_b_idle_blocked", int'(req_b_ready), 0);
    checkOutput("lock_a_sel", int'(sel_baud), 2);
    @(negedge sys_clk);
    cfg_lock = 1'b0;
    #1;
    checkOutput("unlock_b_ready", int'(req_b_ready), 1);
    @(negedge sys_clk);
    req_b_valid = 1'b0;
    waitDone(400, cyc, b_seen);
    checkOutput("unlock_b_done_seen", int'(cyc > 0), 1);
    checkOutput("unlock_b_sel", int'(sel_baud), 3);
`endif

    @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
